// File: rtl/imem_loader.sv
// Boot-time instruction store: packs a little-endian byte stream into 32-bit words and holds the CPU
// in reset until the image is loaded. Define LOADER_CHECKSUM_EN to require an 8-bit sum trailer byte.
module imem_loader #(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] address,
    output logic [31:0] instruction,
    output logic        cpu_reset,
    output logic        done,
    output logic        error
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int CW = $clog2(DEPTH_WORDS + 1);
    localparam logic [15:0] MAX_LEN = 16'(DEPTH_WORDS);

    typedef enum logic [2:0] {
        S_LEN0,
        S_LEN1,
        S_DATA,
`ifdef LOADER_CHECKSUM_EN
        S_CSUM,
`endif
        S_DONE,
        S_ERR
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [15:0]    len;
    logic [CW-1:0]  word_idx;
    logic [1:0]     lane;
    logic [23:0]    shift;
    logic           xfer;
    logic           word_done;
    logic           last_word;
    logic [15:0]    len_full;
    logic [61:0]    fetch_idx;
    logic           fetch_hit;
    logic           unused_addr;

    logic [31:0]    mem [DEPTH_WORDS];

`ifdef LOADER_CHECKSUM_EN
    logic [7:0]     sum;
    logic [7:0]     sum_next;
    assign sum_next = sum + in_data;
`endif

    assign xfer      = in_valid & in_ready;
    assign word_done = xfer && (state == S_DATA) && (lane == 2'd3);
    assign len_full  = {in_data, len[7:0]};
    assign last_word = (lane == 2'd3) && ((16'(word_idx) + 16'd1) == len);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_LEN0;
        end else begin
            state <= state_next;
        end
    end

    // Outputs decode from the state register only; transitions use in_valid
    // directly because in_ready is already 1 in every state that advances.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        cpu_reset  = 1'b1;
        done       = 1'b0;
        error      = 1'b0;
        case (state)
            S_LEN0: begin
                in_ready = 1'b1;
                if (in_valid) state_next = S_LEN1;
            end
            S_LEN1: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (len_full > MAX_LEN) begin
                        state_next = S_ERR;
                    end else if (len_full == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
                        state_next = S_CSUM;
`else
                        state_next = S_DONE;
`endif
                    end else begin
                        state_next = S_DATA;
                    end
                end
            end
            S_DATA: begin
                in_ready = 1'b1;
                if (in_valid && last_word) begin
`ifdef LOADER_CHECKSUM_EN
                    state_next = S_CSUM;
`else
                    state_next = S_DONE;
`endif
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CSUM: begin
                in_ready = 1'b1;
                if (in_valid) state_next = (sum_next == 8'h00) ? S_DONE : S_ERR;
            end
`endif
            S_DONE: begin
                cpu_reset = 1'b0;
                done      = 1'b1;
            end
            S_ERR: begin
                error = 1'b1;
            end
            default: state_next = S_LEN0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len      <= '0;
            word_idx <= '0;
            lane     <= '0;
            shift    <= '0;
`ifdef LOADER_CHECKSUM_EN
            sum      <= '0;
`endif
        end else if (xfer) begin
`ifdef LOADER_CHECKSUM_EN
            sum <= sum_next;
`endif
            case (state)
                S_LEN0: len[7:0]  <= in_data;
                S_LEN1: len[15:8] <= in_data;
                S_DATA: begin
                    // Bytes arrive LSB first, so shifting right leaves byte 0 at [7:0].
                    shift <= {in_data, shift[23:8]};
                    lane  <= lane + 2'd1;
                    if (lane == 2'd3) word_idx <= word_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (word_done) mem[word_idx[AW-1:0]] <= {in_data, shift};
    end

    // Full-width compare so addresses beyond the store (or beyond the loaded
    // count) read as zero instead of aliasing.
    assign fetch_idx   = address[63:2];
    assign fetch_hit   = (state == S_DONE) && (fetch_idx < 62'(word_idx));
    assign instruction = fetch_hit ? mem[fetch_idx[AW-1:0]] : 32'h0000_0000;
    assign unused_addr = ^address[1:0];

endmodule
